// File: rtl/mem_arb_pkg.sv
// Shared definitions for the round-robin memory arbiter: FSM encoding and default sizes.
package mem_arb_pkg;

    localparam int AWIDTH_DEF  = 5;
    localparam int DWIDTH_DEF  = 32;
    localparam int NREQ_DEF    = 2;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus bundle of mem_arbiter; slave = arbiter view, master = environment view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int NREQ   = NREQ_DEF
) ();

    logic [NREQ-1:0]        a_i_cyc;
    logic [NREQ-1:0]        a_i_stb;
    logic [NREQ-1:0]        a_i_we;
    logic [NREQ*AWIDTH-1:0] a_i_addr;
    logic [NREQ*DWIDTH-1:0] a_i_data;
    logic [NREQ-1:0]        a_o_stall;
    logic [NREQ-1:0]        a_o_ack;
    logic [NREQ-1:0]        a_o_err;
    logic [DWIDTH-1:0]      a_o_rdata;
    logic                   a_o_busy;
    logic                   a_o_mem_cyc;
    logic                   a_o_mem_stb;
    logic                   a_o_mem_we;
    logic [AWIDTH-1:0]      a_o_mem_load_addr;
    logic [AWIDTH-1:0]      a_o_mem_store_addr;
    logic [DWIDTH-1:0]      a_o_mem_data;
    logic [DWIDTH-1:0]      a_i_mem_rdata;
    logic                   a_i_mem_ack;
    logic                   a_i_mem_stall;

    modport slave (
        input  a_i_cyc, a_i_stb, a_i_we, a_i_addr, a_i_data,
        output a_o_stall, a_o_ack, a_o_err, a_o_rdata, a_o_busy,
        output a_o_mem_cyc, a_o_mem_stb, a_o_mem_we,
        output a_o_mem_load_addr, a_o_mem_store_addr, a_o_mem_data,
        input  a_i_mem_rdata, a_i_mem_ack, a_i_mem_stall
    );

    modport master (
        output a_i_cyc, a_i_stb, a_i_we, a_i_addr, a_i_data,
        input  a_o_stall, a_o_ack, a_o_err, a_o_rdata, a_o_busy,
        input  a_o_mem_cyc, a_o_mem_stb, a_o_mem_we,
        input  a_o_mem_load_addr, a_o_mem_store_addr, a_o_mem_data,
        output a_i_mem_rdata, a_i_mem_ack, a_i_mem_stall
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping NREQ-1 -> 0.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx
);

    logic found_s;
    logic hit_s;
    int   cand_s;

    // Scan offsets 1..NREQ from last_grant; the first pending requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        cand_s    = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand_s         = (int'(last_grant) + off) % NREQ;
            hit_s          = !found_s && req[cand_s];
            grant[cand_s]  = grant[cand_s] | hit_s;
            grant_idx      = hit_s ? IDXW'(cand_s) : grant_idx;
            found_s        = found_s | hit_s;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NREQ requesters.
// Optional WAIT timeout with per-requester error pulse when ARB_TIMEOUT_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int NREQ   = NREQ_DEF
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input logic          a_clk,
    input logic          a_rst,
    mem_arbiter_if.slave bus
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    logic [NREQ-1:0]   req_s;
    logic [NREQ-1:0]   pick_onehot_s;
    logic [IDXW-1:0]   pick_idx_s;
    logic [IDXW-1:0]   grant_r;
    logic [IDXW-1:0]   last_grant_r;
    logic              latch_s;
    logic              done_s;
    logic              tmo_s;
    logic              sel_we_s;
    logic [AWIDTH-1:0] sel_addr_s;
    logic [DWIDTH-1:0] sel_data_s;
    logic              we_r;
    logic [AWIDTH-1:0] addr_r;
    logic [DWIDTH-1:0] data_r;
    logic [NREQ-1:0]   ack_r;
    logic [NREQ-1:0]   err_r;
    logic [DWIDTH-1:0] rdata_r;
    logic              busy_r;
    logic              mem_cyc_r;
    logic              mem_stb_r;
    logic [NREQ-1:0]   stall_s;
    logic [NREQ-1:0]   grant_onehot_s;

    assign req_s          = bus.a_i_cyc & bus.a_i_stb;
    assign grant_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_r;

    rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (pick_onehot_s),
        .grant_idx  (pick_idx_s)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] wait_cnt_r;

    // WAIT-cycle counter; held at zero outside WAIT so it is clear on entry.
    always_ff @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            wait_cnt_r <= '0;
        end else if (state_r != WAIT) begin
            wait_cnt_r <= '0;
        end else begin
            wait_cnt_r <= wait_cnt_r + CNTW'(1);
        end
    end

    // Abort at the end of the TIMEOUT-th WAIT cycle unless the ack arrives then.
    assign tmo_s = (state_r == WAIT) && !bus.a_i_mem_ack && (wait_cnt_r == CNTW'(TIMEOUT - 1));
`else
    assign tmo_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state; acks outside WAIT are simply not looked at.
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req_s) begin
                    state_nxt_s = ISSUE;
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (bus.a_i_mem_stall) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (bus.a_i_mem_ack) begin
                    state_nxt_s = IDLE;
                    done_s      = 1'b1;
                end else if (tmo_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Select the winning requester's we/addr/data for latching.
    always_comb begin
        sel_we_s   = 1'b0;
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_we_s   = (pick_idx_s == IDXW'(i)) ? bus.a_i_we[i] : sel_we_s;
            sel_addr_s = (pick_idx_s == IDXW'(i)) ? bus.a_i_addr[i*AWIDTH +: AWIDTH] : sel_addr_s;
            sel_data_s = (pick_idx_s == IDXW'(i)) ? bus.a_i_data[i*DWIDTH +: DWIDTH] : sel_data_s;
        end
    end

    // Only the IDLE winner proceeds; with nothing pending nobody is stalled.
    always_comb begin
        stall_s = {NREQ{1'b1}};
        if (state_r == IDLE) begin
            if (|req_s) begin
                stall_s = ~pick_onehot_s;
            end else begin
                stall_s = '0;
            end
        end else begin
            stall_s = {NREQ{1'b1}};
        end
    end

    // Transaction latch, response registers and registered memory controls.
    always_ff @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            grant_r      <= '0;
            last_grant_r <= IDXW'(NREQ - 1);
            we_r         <= 1'b0;
            addr_r       <= '0;
            data_r       <= '0;
            ack_r        <= '0;
            err_r        <= '0;
            rdata_r      <= '0;
            busy_r       <= 1'b0;
            mem_cyc_r    <= 1'b0;
            mem_stb_r    <= 1'b0;
        end else begin
            if (latch_s) begin
                grant_r <= pick_idx_s;
                we_r    <= sel_we_s;
                addr_r  <= sel_addr_s;
                data_r  <= sel_data_s;
            end else begin
                grant_r <= grant_r;
            end
            ack_r <= done_s ? grant_onehot_s : '0;
            err_r <= tmo_s  ? grant_onehot_s : '0;
            if (done_s) begin
                rdata_r <= bus.a_i_mem_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
            if (done_s || tmo_s) begin
                last_grant_r <= grant_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
            busy_r    <= (state_nxt_s != IDLE);
            mem_cyc_r <= (state_nxt_s != IDLE);
            mem_stb_r <= (state_nxt_s == ISSUE);
        end
    end

    assign bus.a_o_stall          = stall_s;
    assign bus.a_o_ack            = ack_r;
`ifdef ARB_TIMEOUT_EN
    assign bus.a_o_err            = err_r;
`else
    assign bus.a_o_err            = err_r & {NREQ{1'b0}};
`endif
    assign bus.a_o_rdata          = rdata_r;
    assign bus.a_o_busy           = busy_r;
    assign bus.a_o_mem_cyc        = mem_cyc_r;
    assign bus.a_o_mem_stb        = mem_stb_r;
    assign bus.a_o_mem_we         = we_r;
    assign bus.a_o_mem_load_addr  = addr_r;
    assign bus.a_o_mem_store_addr = addr_r;
    assign bus.a_o_mem_data       = data_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered single-cycle-ack memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;

    logic a_clk;
    logic a_rst;
    logic mem_mute;
    logic [DW-1:0] mem [0:31];
    int n_checks;
    int n_fail;
    logic [NR-1:0] seen;

    mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW), .NREQ(NR)) bus ();

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NREQ(NR)) dut (
        .a_clk (a_clk),
        .a_rst (a_rst),
        .bus   (bus)
    );

    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    // Memory model: accepts cyc&stb when not stalled, answers one cycle later.
    always @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            bus.a_i_mem_ack   <= 1'b0;
            bus.a_i_mem_rdata <= '0;
        end else begin
            bus.a_i_mem_ack <= bus.a_o_mem_cyc & bus.a_o_mem_stb & ~bus.a_i_mem_stall & ~mem_mute;
            if (bus.a_o_mem_cyc & bus.a_o_mem_stb & ~bus.a_i_mem_stall) begin
                bus.a_i_mem_rdata <= mem[bus.a_o_mem_load_addr];
                if (bus.a_o_mem_we) mem[bus.a_o_mem_store_addr] <= bus.a_o_mem_data;
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_n();
        @(negedge a_clk);
    endtask

    task automatic set_req(input int i, input logic on, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
        bus.a_i_cyc[i] = on;
        bus.a_i_stb[i] = on;
        bus.a_i_we[i]  = we;
        bus.a_i_addr[i*AW +: AW] = addr;
        bus.a_i_data[i*DW +: DW] = data;
    endtask

    task automatic wait_ack(input int budget, output logic [NR-1:0] s);
        s = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge a_clk);
            if (bus.a_o_ack != '0) begin
                s = bus.a_o_ack;
                break;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mem_mute = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[7] = 32'hDEADBEEF;
        mem[1] = 32'hAAAA0001;
        mem[2] = 32'hBBBB0002;
        a_rst = 1'b0;
        bus.a_i_cyc = '0; bus.a_i_stb = '0; bus.a_i_we = '0;
        bus.a_i_addr = '0; bus.a_i_data = '0;
        bus.a_i_mem_stall = 1'b0;
        repeat (3) cyc_n();
        check("rst_ack", bus.a_o_ack, 32'h0);
        check("rst_busy", bus.a_o_busy, 32'h0);
        check("rst_cyc", bus.a_o_mem_cyc, 32'h0);
        check("rst_stall", bus.a_o_stall, 32'h0);
        check("rst_rdata", bus.a_o_rdata, 32'h0);
        a_rst = 1'b1;
        cyc_n();

        // Single read of word 7 by requester 0
        set_req(0, 1'b1, 1'b0, 5'd7, 32'h0);
        #1 check("rd_stall_c0", bus.a_o_stall, 32'h2);
        cyc_n();
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("rd_stb_c1", bus.a_o_mem_stb, 32'h1);
        check("rd_addr_c1", bus.a_o_mem_load_addr, 32'h7);
        check("rd_stall_c1", bus.a_o_stall, 32'h3);
        check("rd_busy_c1", bus.a_o_busy, 32'h1);
        cyc_n();
        check("rd_stb_c2", bus.a_o_mem_stb, 32'h0);
        check("rd_cyc_c2", bus.a_o_mem_cyc, 32'h1);
        check("rd_ack_c2", bus.a_o_ack, 32'h0);
        check("rd_stall1_c2", bus.a_o_stall[1], 32'h1);
        cyc_n();
        check("rd_ack_c3", bus.a_o_ack, 32'h1);
        check("rd_rdata", bus.a_o_rdata, 32'hDEADBEEF);
        check("rd_busy_c3", bus.a_o_busy, 32'h0);
        cyc_n();
        check("rd_ack_pulse", bus.a_o_ack, 32'h0);

        // Requester 1 writes word 3 then reads it back
        set_req(1, 1'b1, 1'b1, 5'd3, 32'h12345678);
        #1 check("wr_stall_c0", bus.a_o_stall, 32'h1);
        cyc_n();
        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("wr_we", bus.a_o_mem_we, 32'h1);
        check("wr_data", bus.a_o_mem_data, 32'h12345678);
        check("wr_saddr", bus.a_o_mem_store_addr, 32'h3);
        wait_ack(6, seen);
        check("wr_ack", seen, 32'h2);
        set_req(1, 1'b1, 1'b0, 5'd3, 32'h0);
        cyc_n();
        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);
        wait_ack(6, seen);
        check("rb_ack", seen, 32'h2);
        check("rb_rdata", bus.a_o_rdata, 32'h12345678);

        // Contention: both hold requests; grants must alternate 0,1,0,1
        set_req(0, 1'b1, 1'b0, 5'd1, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(10, seen);
            check("cont_ack", seen, (k % 2 == 0) ? 32'h1 : 32'h2);
            check("cont_rdata", bus.a_o_rdata, (k % 2 == 0) ? 32'hAAAA0001 : 32'hBBBB0002);
        end
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);
        repeat (2) cyc_n();
        check("cont_idle", bus.a_o_busy, 32'h0);

        // Memory stall for 3 cycles in ISSUE delays the ack by 3 cycles
        set_req(0, 1'b1, 1'b0, 5'd7, 32'h0);
        bus.a_i_mem_stall = 1'b1;
        cyc_n();
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            check("stl_stb", bus.a_o_mem_stb, 32'h1);
            check("stl_addr", bus.a_o_mem_load_addr, 32'h7);
            if (c == 4) bus.a_i_mem_stall = 1'b0;
            cyc_n();
        end
        check("stl_stb_off", bus.a_o_mem_stb, 32'h0);
        check("stl_ack_c5", bus.a_o_ack, 32'h0);
        cyc_n();
        check("stl_ack_c6", bus.a_o_ack, 32'h1);
        check("stl_rdata", bus.a_o_rdata, 32'hDEADBEEF);

        // Reset while in WAIT: silent abort, pointer back to requester 0
        set_req(1, 1'b1, 1'b0, 5'd2, 32'h0);
        cyc_n();
        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc_n();
        check("mr_busy_pre", bus.a_o_busy, 32'h1);
        #2 a_rst = 1'b0;
        #1 check("mr_busy", bus.a_o_busy, 32'h0);
        check("mr_cyc", bus.a_o_mem_cyc, 32'h0);
        check("mr_stb", bus.a_o_mem_stb, 32'h0);
        check("mr_ack", bus.a_o_ack, 32'h0);
        cyc_n();
        a_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc_n();
            check("mr_noack", bus.a_o_ack, 32'h0);
        end
        set_req(0, 1'b1, 1'b0, 5'd1, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'h0);
        #1 check("mr_winner", bus.a_o_stall, 32'h2);
        cyc_n();
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);
        wait_ack(6, seen);
        check("mr_ack0", seen, 32'h1);
        repeat (2) cyc_n();

`ifdef ARB_TIMEOUT_EN
        // Suppressed memory ack: err pulse after 15 WAIT cycles, then requester 1 served
        mem_mute = 1'b1;
        set_req(0, 1'b1, 1'b0, 5'd7, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'h0);
        begin
            int cyc_cnt;
            cyc_cnt = 0;
            seen = '0;
            for (int c = 1; c <= 40; c++) begin
                cyc_n();
                if (c == 1) set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
                if (bus.a_o_err != '0) begin
                    cyc_cnt = c;
                    seen = bus.a_o_err;
                    break;
                end
            end
            check("to_err", seen, 32'h1);
            check("to_cycle", cyc_cnt, 32'd17);
        end
        check("to_noack", bus.a_o_ack, 32'h0);
        check("to_busy", bus.a_o_busy, 32'h0);
        set_req(0, 1'b1, 1'b0, 5'd7, 32'h0);
        #1 check("to_next", bus.a_o_stall, 32'h1);
        mem_mute = 1'b0;
        cyc_n();
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);
        wait_ack(6, seen);
        check("to_ack1", seen, 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter sharing the single-port data memory (5-bit address, 32-bit data, single-cycle ack) between NREQ bus requesters, e.g. instruction fetch and load/store unit.
- Latches the winning request, issues one memory transaction, and routes the ack and read data back to the winner.
- Sits between the requesters and the memory; it is the only master on the memory's cyc/stb interface.

Parameters:
- AWIDTH, 5: memory address width.
- DWIDTH, 32: data width.
- NREQ, 2: number of requesters (2..8).
- TIMEOUT, 15: cycles in WAIT before abort; used only with ARB_TIMEOUT_EN.

Ports:
- a_clk  in  1  clock, rising edge.
- a_rst  in  1  asynchronous active-low reset.
- a_i_cyc  in  NREQ  per-requester bus cycle.
- a_i_stb  in  NREQ  per-requester strobe.
- a_i_we  in  NREQ  per-requester write enable.
- a_i_addr  in  NREQ*AWIDTH  packed addresses; requester i at [i*AWIDTH +: AWIDTH].
- a_i_data  in  NREQ*DWIDTH  packed write data.
- a_o_stall  out  NREQ  per-requester stall.
- a_o_ack  out  NREQ  per-requester ack, one-cycle pulse.
- a_o_err  out  NREQ  per-requester timeout error pulse.
- a_o_rdata  out  DWIDTH  shared read-data return, valid with ack.
- a_o_busy  out  1  high when state is not IDLE.
- a_o_mem_cyc, a_o_mem_stb, a_o_mem_we  out  1 each  memory control.
- a_o_mem_load_addr, a_o_mem_store_addr  out  AWIDTH each  both driven with the latched address.
- a_o_mem_data  out  DWIDTH  latched write data.
- a_i_mem_rdata  in  DWIDTH  memory read data.
- a_i_mem_ack  in  1  memory ack.
- a_i_mem_stall  in  1  memory stall.

Behaviour:
- Clock and reset: one clock a_clk; a_rst asynchronous, active-low.
- Reset values:
  - All registered outputs 0.
  - State IDLE.
  - Round-robin pointer selects requester 0 first.
  - Latched we/addr/data = 0.
  - Reset mid-transaction aborts silently: no ack or err is issued.
- Request: req[i] = a_i_cyc[i] & a_i_stb[i].
- a_o_stall is combinational:
  - a_o_stall[i] = 0 only in IDLE when i is the arbitration winner; all other bits 1.
  - Exception: all bits are 0 in IDLE when no request is pending.
- States IDLE, ISSUE, WAIT:
  - IDLE: if any req, pick the winner by round robin, searching from last_grant+1 with wrap at NREQ-1 -> 0. Latch grant, we, addr, data; go to ISSUE. With no req, stay.
  - ISSUE: mem_cyc=1, mem_stb=1. If a_i_mem_stall, hold ISSUE with unchanged outputs; else go to WAIT.
  - WAIT: mem_cyc=1, mem_stb=0. On a_i_mem_ack, register a_o_ack[grant]=1 and a_o_rdata=a_i_mem_rdata (rdata is captured for writes too), set last_grant=grant, go to IDLE.
- Latency (no stall):
  - Request visible at edge 0.
  - Memory stb high in cycle 1.
  - Memory ack in cycle 2.
  - Requester ack in cycle 3.
  - Next grant evaluated in cycle 3.
- An ack in ISSUE, or while not expected, is ignored.
- A requester dropping cyc after grant does not cancel the transaction: it completes and acks.
- a_o_ack and a_o_err are one-hot or zero, never both set.
- Requesters deassert stb after their stall is low, or re-request for the next arbitration.
- Fairness: after requester k is served, every other pending requester is served before k again.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without ack, pulse a_o_err[grant] for one cycle (no ack), drop mem_cyc, and go to IDLE; last_grant updates.
  - Counter width is $clog2(TIMEOUT+1).
- Undefined: WAIT is unbounded and a_o_err is tied to 0.

Decomposition:
- Shared package/header mem_arb_pkg:
  - State encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
  - Default widths.
  - TIMEOUT default.
- Sub-module rr_picker (NREQ): combinational; inputs req vector and last_grant; outputs a one-hot grant and its index.

Test Plan:
- Single read: memory word 7 preloaded 32'hDEADBEEF; req0 reads addr 7 -> a_o_ack[0] pulses in cycle 3, a_o_rdata=32'hDEADBEEF, a_o_stall[1] held 1 throughout.
- Write then read: req1 writes 32'h12345678 to addr 3, then reads addr 3 -> two acks to requester 1, the second with rdata 32'h12345678.
- Contention: req0 and req1 both continuously request from reset -> grant order 0,1,0,1; no requester is acked twice consecutively.
- Memory stall: a_i_mem_stall held high 3 cycles in ISSUE -> mem_stb stays 1 with stable address; ack is delayed by exactly 3 cycles.
- Reset mid-WAIT: a_rst low while busy -> all outputs 0 asynchronously; no ack after release; the next request is granted to requester 0.
- With ARB_TIMEOUT_EN, TIMEOUT=15, memory ack suppressed -> a_o_err[grant] pulses after 15 WAIT cycles, busy drops, and the next requester is granted.
